nunchuck_i2c_responder: RTL and testbench
=========================================

// Module: nunchuck_i2c_responder
// PURPOSE
//  I2C target emulating a Wii nunchuck at 7-bit address 0x52, open-drain on SDA; it never drives SCL.
//  Serves the six-byte nunchuck report from parallel inputs, so the game's nunchuck master can be
//  exercised in simulation and board loopback without a physical controller. Sits beside the master
//  on a shared SCL/SDA pair in the test top, or alone in the bench.
// PARAMETERS
//  DEV_ADDR     7'h52  target address matched in the address byte
//  SYNC_STAGES  2      flops per synchroniser on scl_in/sda_in (>=2)
//  HOLD_CYCLES  4      clk cycles after detected SCL fall before sda_oe may change (< SCL low time)
// PORTS
//  clk        in   1   system clock (50 MHz)
//  rst        in   1   reset, asynchronous, active-high
//  scl_in     in   1   bus SCL level (async)
//  sda_in     in   1   bus SDA level (async)
//  sda_oe     out  1   1 = pull SDA low; 0 = release
//  stick_x    in   8   joystick X      stick_y  in  8   joystick Y
//  accel_x    in   10  accel X  accel_y  in  10  accel Y  accel_z  in  10  accel Z
//  z, c       in   1   buttons, 1 = pressed
//  busy       out  1   1 from address match until STOP or repeated START
//  wr_strobe  out  1   1-cycle pulse per accepted write data byte (pointer byte excluded)
//  wr_reg     out  8   register written (valid with wr_strobe)
//  wr_data    out  8   data written (valid with wr_strobe)
//  rd_done    out  1   1-cycle pulse when a read transfer ends (master NACK or STOP)
//  init_done  out  1   sticky; set when 0x55 is written to reg 0xF0
// BEHAVIOUR
//  Reset: sda_oe=0, busy=0, wr_strobe=0, rd_done=0, init_done=0, wr_reg=wr_data=0, pointer=0,
//   state IDLE. sda_oe clears asynchronously at rst assertion.
//  SCL and SDA are each synchronised through SYNC_STAGES flops, then edge-detected.
//  START = SDA fall while SCL high; STOP = SDA rise while SCL high. Detected in every state.
//  Bit timing: sample SDA on SCL rise; update sda_oe HOLD_CYCLES after SCL fall. MSB first.
//  FSM: IDLE -> (START) ADDR -> 8 bits shifted -> ADDR_ACK.
//   ADDR_ACK: address==DEV_ADDR drives ACK for the 9th clock, sets busy; then R/W=0 -> WR_DATA,
//    R/W=1 -> snapshot inputs and enter RD_DATA. Mismatch: no ACK, sda_oe stays 0, go to WAIT_STOP.
//   WR_DATA/WR_ACK: every byte is ACKed. The first byte after the address loads the pointer.
//    Each later byte pulses wr_strobe (wr_reg=pointer), then pointer increments mod 256.
//    A write of reg 0xF0 with data 0x55 sets init_done. Other registers are accepted and discarded.
//   RD_DATA: drives the byte at pointer, sda_oe = ~bit. RD_ACK: release SDA, sample the master's bit.
//    ACK -> pointer+1, next byte. NACK -> release, pulse rd_done, WAIT_STOP.
//   WAIT_STOP: sda_oe=0. STOP -> IDLE; START -> ADDR.
//  Repeated START in any state -> ADDR with the pointer kept. STOP in any state -> IDLE, busy=0.
//   A STOP during RD_DATA/RD_ACK pulses rd_done.
//  Read map, taken from a snapshot latched at the read ADDR_ACK so all six bytes are coherent:
//   0:stick_x  1:stick_y  2:accel_x[9:2]  3:accel_y[9:2]  4:accel_z[9:2]
//   5:{accel_z[1:0],accel_y[1:0],accel_x[1:0],~c,~z}
//   pointer >= 6 -> 0xFF
// CONFIGURATION
//  NUNCHUCK_LEGACY_XOR_EN defined:
//   While init_done=0, each read byte b is sent as ((b ^ 8'h17) + 8'h17) mod 256 (legacy encoding).
//   Once init_done=1, bytes are sent plain.
//  NUNCHUCK_LEGACY_XOR_EN undefined: bytes are always sent plain. init_done is still tracked.
// STRUCTURE
//  Package nunchuck_pkg holds:
//   NUNCHUCK_ADDR=7'h52, REG_INIT1=8'hF0, INIT1_VAL=8'h55, REG_INIT2=8'hFB, REPORT_LEN=6
//   typedef enum i2c_tgt_state_t {IDLE,ADDR,ADDR_ACK,WR_DATA,WR_ACK,RD_DATA,RD_ACK,WAIT_STOP}
//   function nunchuck_encode(byte)
//  Sub-module i2c_line_sync: synchronisers plus scl_rise/scl_fall/start/stop pulse outputs.
// TESTING
//  1. W 0x52, 0xF0, 0x55, STOP -> ACK on all three bytes; wr_strobe with reg F0, data 55; init_done=1.
//  2. After init: W 0x52, 0x00; Sr R 0x52, read 6 with sx=80 sy=7F ax=200 ay=1FF az=3FF z=1 c=0
//     -> bytes 80 7F 80 7F FF F2.
//  3. Address 0x53 (W or R) -> sda_oe stays 0 for the whole transfer; busy=0; IDLE after STOP.
//  4. Change all inputs after byte 1 of a read -> remaining bytes match the snapshot.
//     Master NACK on byte 3 -> SDA released, rd_done pulses once.
//  5. Assert rst while sda_oe=1 in RD_DATA -> sda_oe=0 with no clk edge. Repeated START mid-write
//     -> new address phase is ACKed and the pointer is kept.
//  6. NUNCHUCK_LEGACY_XOR_EN with no init, read byte 0 with sx=0x80 -> 0xAE. After 0xF0<=0x55 -> 0x80.

Source files
------------

// File: rtl/nunchuck_pkg.sv
// nunchuck_pkg: shared constants, target FSM states and the legacy byte encoding for the nunchuck responder
package nunchuck_pkg;
   localparam logic [6:0] NUNCHUCK_ADDR = 7'h52;
   localparam logic [7:0] REG_INIT1     = 8'hF0;
   localparam logic [7:0] INIT1_VAL     = 8'h55;
   localparam logic [7:0] REG_INIT2     = 8'hFB;
   localparam int         REPORT_LEN    = 6;

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
   } i2c_tgt_state_t;

   function automatic logic [7:0] nunchuck_encode(input logic [7:0] b);
      return (b ^ 8'h17) + 8'h17;
   endfunction
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: synchronises SCL/SDA and flags SCL edges plus START/STOP conditions
module i2c_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic scl_in,
   input  logic sda_in,
   output logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic start,
   output logic stop
);
   logic [SYNC_STAGES-1:0] scl_sr, sda_sr;
   logic scl, scl_q, sda_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         scl_sr <= '1;
         sda_sr <= '1;
         scl_q  <= 1'b1;
         sda_q  <= 1'b1;
      end else begin
         scl_sr <= {scl_sr[SYNC_STAGES-2:0], scl_in};
         sda_sr <= {sda_sr[SYNC_STAGES-2:0], sda_in};
         scl_q  <= scl;
         sda_q  <= sda;
      end
   assign scl      = scl_sr[SYNC_STAGES-1];
   assign sda      = sda_sr[SYNC_STAGES-1];
   assign scl_rise = scl & ~scl_q;
   assign scl_fall = ~scl & scl_q;
   assign start    = scl & scl_q & sda_q & ~sda;
   assign stop     = scl & scl_q & ~sda_q & sda;
endmodule

// File: rtl/nunchuck_i2c_responder.sv
// nunchuck_i2c_responder: I2C target emulating a Wii nunchuck (six-byte report, init register tracking).
// Optional NUNCHUCK_LEGACY_XOR_EN: read bytes are legacy-encoded until init_done is set.
module nunchuck_i2c_responder
   import nunchuck_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR    = NUNCHUCK_ADDR,
   parameter int         SYNC_STAGES = 2,
   parameter int         HOLD_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   input  logic [7:0] stick_x,
   input  logic [7:0] stick_y,
   input  logic [9:0] accel_x,
   input  logic [9:0] accel_y,
   input  logic [9:0] accel_z,
   input  logic       z,
   input  logic       c,
   output logic       busy,
   output logic       wr_strobe,
   output logic [7:0] wr_reg,
   output logic [7:0] wr_data,
   output logic       rd_done,
   output logic       init_done
);
   i2c_tgt_state_t state, state_nxt;
   logic sda, scl_rise, scl_fall, start, stop, tick, first, match;
   logic [7:0] hcnt, sr, ptr, tx_raw, tx;
   logic [3:0] cnt;
   logic [2:0] bi;
   logic [7:0] snap [REPORT_LEN];

   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in), .sda(sda),
      .scl_rise(scl_rise), .scl_fall(scl_fall), .start(start), .stop(stop)
   );

   // tick marks the point after an SCL fall where SDA may safely change
   assign tick   = hcnt == 8'd1;
   assign match  = sr[7:1] == DEV_ADDR;
   assign bi     = 3'd7 - cnt[2:0];
   assign tx_raw = ptr < 8'(REPORT_LEN) ? snap[ptr[2:0]] : 8'hFF;
`ifdef NUNCHUCK_LEGACY_XOR_EN
   assign tx = init_done ? tx_raw : nunchuck_encode(tx_raw);
`else
   assign tx = tx_raw;
`endif

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nxt;

   always_comb begin
      state_nxt = state;
      if (start) state_nxt = ADDR;
      else if (stop) state_nxt = IDLE;
      else
         case (state)
            ADDR:     if (tick && cnt == 4'd8) state_nxt = match ? ADDR_ACK : WAIT_STOP;
            ADDR_ACK: if (tick) state_nxt = sr[0] ? RD_DATA : WR_DATA;
            WR_DATA:  if (tick && cnt == 4'd8) state_nxt = WR_ACK;
            WR_ACK:   if (tick) state_nxt = WR_DATA;
            RD_DATA:  if (tick && cnt == 4'd8) state_nxt = RD_ACK;
            RD_ACK:   state_nxt = scl_rise && sda ? WAIT_STOP : tick ? RD_DATA : RD_ACK;
            default:  state_nxt = state;
         endcase
   end

   always_ff @(posedge clk)
      if (state == ADDR && tick && cnt == 4'd8 && match && sr[0])
         snap <= '{stick_x, stick_y, accel_x[9:2], accel_y[9:2], accel_z[9:2],
                   {accel_z[1:0], accel_y[1:0], accel_x[1:0], ~c, ~z}};

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sda_oe    <= 1'b0;
         busy      <= 1'b0;
         wr_strobe <= 1'b0;
         wr_reg    <= 8'h00;
         wr_data   <= 8'h00;
         rd_done   <= 1'b0;
         init_done <= 1'b0;
         hcnt      <= 8'h00;
         sr        <= 8'h00;
         ptr       <= 8'h00;
         cnt       <= 4'd0;
         first     <= 1'b1;
      end else begin
         wr_strobe <= 1'b0;
         rd_done   <= 1'b0;
         hcnt      <= scl_fall ? 8'(HOLD_CYCLES) : hcnt != 8'h00 ? hcnt - 8'd1 : hcnt;
         if (start || stop) begin
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            cnt     <= 4'd0;
            first   <= 1'b1;
            rd_done <= stop && (state == RD_DATA || state == RD_ACK);
         end else begin
            if (scl_rise && (state == ADDR || state == WR_DATA || state == RD_DATA)) cnt <= cnt + 4'd1;
            if (scl_rise && (state == ADDR || state == WR_DATA)) sr <= {sr[6:0], sda};
            case (state)
               ADDR:
                  if (tick && cnt == 4'd8) begin
                     cnt    <= 4'd0;
                     sda_oe <= match;
                     busy   <= match;
                  end
               ADDR_ACK: if (tick) sda_oe <= sr[0] & ~tx[7];
               WR_DATA:
                  if (tick && cnt == 4'd8) begin
                     cnt    <= 4'd0;
                     sda_oe <= 1'b1;
                     first  <= 1'b0;
                     if (first) ptr <= sr;
                     else begin
                        wr_strobe <= 1'b1;
                        wr_reg    <= ptr;
                        wr_data   <= sr;
                        ptr       <= ptr + 8'd1;
                        if (ptr == REG_INIT1 && sr == INIT1_VAL) init_done <= 1'b1;
                     end
                  end
               WR_ACK: if (tick) sda_oe <= 1'b0;
               RD_DATA:
                  if (tick) begin
                     sda_oe <= cnt == 4'd8 ? 1'b0 : ~tx[bi];
                     if (cnt == 4'd8) cnt <= 4'd0;
                  end
               RD_ACK: begin
                  // pointer advances on the master's ACK so the next byte is ready at the drive point
                  if (scl_rise) begin
                     if (sda) rd_done <= 1'b1;
                     else ptr <= ptr + 8'd1;
                  end
                  if (tick) sda_oe <= ~tx[7];
               end
               default: sda_oe <= 1'b0;
            endcase
         end
      end
endmodule

// File: tb/tb_nunchuck_i2c_responder.sv
// tb_nunchuck_i2c_responder: bit-banged I2C master driving directed transfers against the responder
module tb_nunchuck_i2c_responder;
   localparam int Q = 20;
   logic clk = 1'b0, rst = 1'b1;
   logic m_scl = 1'b1, m_sda_low = 1'b0, sda_bus;
   logic sda_oe, busy, wr_strobe, rd_done, init_done;
   logic [7:0] wr_reg, wr_data, stick_x = 0, stick_y = 0;
   logic [9:0] accel_x = 0, accel_y = 0, accel_z = 0;
   logic z = 0, c = 0;
   int vectors = 0, miscompares = 0, rd_cnt = 0, wr_cnt = 0;
   logic [7:0] last_reg = 0, last_data = 0;
   logic oe_seen = 0, ack;
   logic [7:0] d;

   always #10 clk = ~clk;
   assign sda_bus = !(m_sda_low || sda_oe);

   nunchuck_i2c_responder dut (
      .clk(clk), .rst(rst), .scl_in(m_scl), .sda_in(sda_bus), .sda_oe(sda_oe),
      .stick_x(stick_x), .stick_y(stick_y), .accel_x(accel_x), .accel_y(accel_y),
      .accel_z(accel_z), .z(z), .c(c), .busy(busy), .wr_strobe(wr_strobe),
      .wr_reg(wr_reg), .wr_data(wr_data), .rd_done(rd_done), .init_done(init_done)
   );

   always @(posedge clk) begin
      if (rd_done) rd_cnt++;
      if (wr_strobe) begin
         wr_cnt++;
         last_reg  = wr_reg;
         last_data = wr_data;
      end
      if (sda_oe) oe_seen = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic q;
      repeat (Q) @(negedge clk);
   endtask

   task automatic i2c_start;
      m_sda_low = 1'b0; q; m_scl = 1'b1; q; m_sda_low = 1'b1; q; m_scl = 1'b0; q;
   endtask

   task automatic i2c_stop;
      m_sda_low = 1'b1; q; m_scl = 1'b1; q; m_sda_low = 1'b0; q;
   endtask

   task automatic write_byte(input logic [7:0] b, output logic a);
      for (int i = 7; i >= 0; i--) begin
         m_sda_low = !b[i]; q; m_scl = 1'b1; q; q; m_scl = 1'b0; q;
      end
      m_sda_low = 1'b0; q; m_scl = 1'b1; q; a = sda_bus; q; m_scl = 1'b0; q;
   endtask

   task automatic read_byte(output logic [7:0] b, input logic nack);
      for (int i = 7; i >= 0; i--) begin
         m_sda_low = 1'b0; q; m_scl = 1'b1; q; b[i] = sda_bus; q; m_scl = 1'b0; q;
      end
      m_sda_low = !nack; q; m_scl = 1'b1; q; q; m_scl = 1'b0; m_sda_low = 1'b0; q;
   endtask

   // write pointer then repeated-START read address; leaves the bus ready for read_byte
   task automatic setup_read(input logic [7:0] p);
      i2c_start; write_byte(8'hA4, ack); write_byte(p, ack);
      i2c_start; write_byte(8'hA5, ack);
      check("rd_addr_ack", ack, 1'b0);
   endtask

   initial begin
      logic [7:0] exp6 [6];
      logic [7:0] exp0;
      int rd0;
      repeat (3) @(negedge clk);
      check("rst_sda_oe", sda_oe, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_init", init_done, 1'b0);
      check("rst_wr", {wr_strobe, rd_done, wr_reg, wr_data}, 18'h0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // legacy encoding before init (plain in default build)
      stick_x = 8'h80;
      setup_read(8'h00);
      read_byte(d, 1'b1);
      i2c_stop;
`ifdef NUNCHUCK_LEGACY_XOR_EN
      exp0 = 8'hAE;
`else
      exp0 = 8'h80;
`endif
      check("preinit_byte0", d, exp0);

      // init write
      i2c_start;
      write_byte(8'hA4, ack); check("t1_addr_ack", ack, 1'b0);
      check("t1_busy", busy, 1'b1);
      write_byte(8'hF0, ack); check("t1_ptr_ack", ack, 1'b0);
      write_byte(8'h55, ack); check("t1_data_ack", ack, 1'b0);
      i2c_stop;
      check("t1_wr_cnt", wr_cnt, 1);
      check("t1_wr_reg", last_reg, 8'hF0);
      check("t1_wr_data", last_data, 8'h55);
      check("t1_init", init_done, 1'b1);
      check("t1_busy_off", busy, 1'b0);

      // full report read
      stick_x = 8'h80; stick_y = 8'h7F; accel_x = 10'h200; accel_y = 10'h1FF; accel_z = 10'h3FF;
      z = 1'b1; c = 1'b0;
      exp6 = '{8'h80, 8'h7F, 8'h80, 8'h7F, 8'hFF, 8'hF2};
      rd0 = rd_cnt;
      setup_read(8'h00);
      for (int i = 0; i < 6; i++) begin
         read_byte(d, i == 5);
         check($sformatf("t2_byte%0d", i), d, exp6[i]);
      end
      i2c_stop;
      check("t2_rd_done", rd_cnt - rd0, 1);

      // wrong address, write and read
      oe_seen = 1'b0;
      i2c_start;
      write_byte(8'hA6, ack); check("t3_w_nack", ack, 1'b1);
      check("t3_busy", busy, 1'b0);
      write_byte(8'h12, ack);
      i2c_stop;
      i2c_start;
      write_byte(8'hA7, ack); check("t3_r_nack", ack, 1'b1);
      read_byte(d, 1'b1);
      i2c_stop;
      check("t3_oe_never", oe_seen, 1'b0);
      check("t3_busy_end", busy, 1'b0);

      // snapshot coherence and master NACK
      stick_x = 8'h11; stick_y = 8'h22; accel_x = 10'h0CC;
      rd0 = rd_cnt;
      setup_read(8'h00);
      read_byte(d, 1'b0); check("t4_byte0", d, 8'h11);
      stick_x = 8'hAA; stick_y = 8'hBB; accel_x = 10'h3FC; accel_y = 10'h2A8;
      read_byte(d, 1'b0); check("t4_byte1", d, 8'h22);
      read_byte(d, 1'b1); check("t4_byte2", d, 8'h33);
      q;
      check("t4_released", sda_oe, 1'b0);
      check("t4_rd_done", rd_cnt - rd0, 1);
      i2c_stop;
      check("t4_rd_done_once", rd_cnt - rd0, 1);

      // repeated START mid-write keeps the pointer
      i2c_start;
      write_byte(8'hA4, ack); write_byte(8'h03, ack);
      i2c_start;
      write_byte(8'hA4, ack); check("t5_sr_ack", ack, 1'b0);
      check("t5_sr_busy", busy, 1'b1);
      i2c_start;
      write_byte(8'hA5, ack);
      read_byte(d, 1'b1);
      i2c_stop;
      check("t5_ptr_kept", d, 8'hAA);

      // asynchronous reset while driving SDA
      stick_x = 8'h00;
      setup_read(8'h00);
      check("t5_oe_driving", sda_oe, 1'b1);
      #3 rst = 1'b1;
      #1 check("t5_async_oe", sda_oe, 1'b0);
      check("t5_async_busy", busy, 1'b0);
      @(negedge clk);
      m_scl = 1'b1; m_sda_low = 1'b0;
      rst = 1'b0;
      q;
      check("t5_init_cleared", init_done, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
